servant_clock_ctrl: RTL and testbench
=====================================

SERVANT_CLOCK_CTRL -- requirements
Module: servant_clock_ctrl

Interface
REQ-001 Parameter RST_HOLD, default 16: cycles that o_rst stays asserted after synchronized lock; legal range 1..255.
REQ-002 Parameter IDLE_CYCLES, default 256: consecutive idle cycles before a channel starts gate-off; legal range 2..65535.
REQ-003 Parameter WAKE_CYCLES, default 4: settle cycles between enabling a clock and acknowledging it; legal range 1..15.
REQ-004 i_clk  in  1  free-running control clock, the un-gated PLL output.
REQ-005 i_rst  in  1  reset; asynchronous, active-low.
REQ-006 i_locked  in  1  PLL lock status; asynchronous to i_clk.
REQ-007 i_req0, i_req1  in  1 each  level activity request per channel; synchronous to i_clk.
REQ-008 i_stop_ack0, i_stop_ack1  in  1 each  consumer agrees to clock stop.
REQ-009 o_clk0_en, o_clk1_en  out  1 each  registered clock-buffer enables.
REQ-010 o_ack0, o_ack1  out  1 each  clock is running and stable.
REQ-011 o_stop_req0, o_stop_req1  out  1 each  gate-off pending.
REQ-012 o_rst  out  1  active-high synchronous reset to downstream logic.
REQ-013 o_ready  out  1  lock is stable and o_rst is released.

Function
REQ-014 i_locked SHALL pass through a 2-flop synchronizer; all following text refers to the synchronized value, written lk.
REQ-015 A hold counter SHALL clear while lk=0 and, while lk=1, count up and saturate at RST_HOLD.
REQ-016 o_rst SHALL be 1 until the hold counter reaches RST_HOLD, and o_ready SHALL equal !o_rst; both outputs are registered.
REQ-017 From the first i_clk edge with i_locked=1, o_rst SHALL deassert exactly RST_HOLD+2 cycles later.
REQ-018 When lk falls, o_rst SHALL assert on the next edge and both channels SHALL force to OFF on that same edge, ignoring any handshake.
REQ-019 Each channel SHALL run an independent FSM with states OFF, WAKE, ON and DRAIN; all outputs are registered from the state.
REQ-020 OFF: en=0, ack=0, stop_req=0; go to WAKE when req=1 and o_ready=1.
REQ-021 WAKE: en=1, ack=0; the settle counter loads on entry; go to ON after WAKE_CYCLES cycles.
REQ-022 ON: en=1, ack=1; a 16-bit idle counter clears on req=1 and otherwise increments, saturating; go to DRAIN when the count reaches IDLE_CYCLES-1 with req=0.
REQ-023 DRAIN: en=1, ack=0, stop_req=1; req=1 returns to ON with the idle counter cleared; otherwise stop_ack=1 goes to OFF.
REQ-024 In DRAIN, simultaneous req=1 and stop_ack=1 SHALL resolve to ON (request wins).
REQ-025 stop_ack SHALL be ignored in every state other than DRAIN.
REQ-026 en SHALL never toggle while o_rst=1; it SHALL be 0 throughout reset.
REQ-027 The two channels SHALL never interact, except that both share o_ready and the loss-of-lock override.

Reset
REQ-028 While i_rst=0: o_rst=1, o_ready=0, all en/ack/stop_req=0, all counters 0, synchronizer flops 0, both FSMs OFF.
REQ-029 Reset assertion SHALL take effect asynchronously; deassertion SHALL be used synchronously via the existing flop structure, with no extra reset synchronizer.

Verification
REQ-030 Bench: i_rst released, i_locked=1 at cycle 0, RST_HOLD=16 -> o_rst=1 through cycle 17, o_rst=0 and o_ready=1 from cycle 18.
REQ-031 Bench: i_req0 rises with o_ready=1 -> o_clk0_en=1 next cycle, o_ack0=1 after WAKE_CYCLES=4 more cycles; channel 1 stays OFF.
REQ-032 Bench: IDLE_CYCLES=8, channel 0 ON, i_req0 drops -> o_stop_req0=1 after 8 cycles; i_stop_ack0 pulse -> o_clk0_en=0 next cycle.
REQ-033 Bench: in DRAIN, i_req0 and i_stop_ack0 both 1 on the same cycle -> state ON, o_ack0=1, o_clk0_en stays 1, idle counter reset.
REQ-034 Bench: both channels ON, i_locked drops -> o_rst=1 within 3 cycles, both en/ack=0; relock -> the REQ-030 sequence repeats.
REQ-035 Bench: i_rst pulsed low mid-WAKE -> all outputs reach reset values immediately, with no en glitch after release until a new request.

Source files
------------

// File: rtl/servant_clock_ctrl.sv
// Clock controller for a PLL-fed subsystem: lock-qualified downstream reset plus two
// independent request-driven clock-gating channels with a stop handshake.
module servant_clock_ctrl #(
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned IDLE_CYCLES = 256,
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_locked,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_stop_ack0,
  input  logic i_stop_ack1,
  output logic o_clk0_en,
  output logic o_clk1_en,
  output logic o_ack0,
  output logic o_ack1,
  output logic o_stop_req0,
  output logic o_stop_req1,
  output logic o_rst,
  output logic o_ready
);

  typedef enum logic [1:0] {StOff, StWake, StOn, StDrain} ch_state_e;

  localparam logic [7:0]  HoldMax  = 8'(RST_HOLD);
  localparam logic [15:0] IdleLast = 16'(IDLE_CYCLES - 1);
  localparam logic [3:0]  WakeLoad = 4'(WAKE_CYCLES - 1);

  logic       sync_q, lk_q;
  logic [7:0] hold_q, hold_d;
  logic       rst_q, rst_d, ready_q;

  logic [1:0]  req, stop_ack;
  ch_state_e   state_q  [2];
  ch_state_e   state_d  [2];
  logic [3:0]  settle_q [2];
  logic [3:0]  settle_d [2];
  logic [15:0] idle_q   [2];
  logic [15:0] idle_d   [2];
  logic [1:0]  en_q, ack_q, stop_req_q;

  assign req      = {i_req1, i_req0};
  assign stop_ack = {i_stop_ack1, i_stop_ack0};

  always_comb begin
    hold_d = '0;
    if (lk_q) begin
      hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 8'd1;
    end
    rst_d = !(lk_q && (hold_q == HoldMax));
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q  <= 1'b0;
      lk_q    <= 1'b0;
      hold_q  <= '0;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      sync_q  <= i_locked;
      lk_q    <= sync_q;
      hold_q  <= hold_d;
      rst_q   <= rst_d;
      ready_q <= !rst_d;
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_d[c]  = state_q[c];
      settle_d[c] = settle_q[c];
      idle_d[c]   = idle_q[c];
      unique case (state_q[c])
        StOff: begin
          if (req[c] && ready_q) begin
            state_d[c]  = StWake;
            settle_d[c] = WakeLoad;
          end
        end
        StWake: begin
          if (settle_q[c] == 4'd0) begin
            state_d[c] = StOn;
            idle_d[c]  = '0;
          end else begin
            settle_d[c] = settle_q[c] - 4'd1;
          end
        end
        StOn: begin
          if (req[c]) begin
            idle_d[c] = '0;
          end else begin
            if (idle_q[c] != 16'hffff) idle_d[c] = idle_q[c] + 16'd1;
            if (idle_q[c] == IdleLast) state_d[c] = StDrain;
          end
        end
        StDrain: begin
          // A fresh request outranks a concurrent stop acknowledge.
          if (req[c]) begin
            state_d[c] = StOn;
            idle_d[c]  = '0;
          end else if (stop_ack[c]) begin
            state_d[c] = StOff;
          end
        end
      endcase
      // Loss of lock kills both clocks immediately, handshake or not.
      if (!lk_q) begin
        state_d[c]  = StOff;
        settle_d[c] = '0;
        idle_d[c]   = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int c = 0; c < 2; c++) begin
        state_q[c]  <= StOff;
        settle_q[c] <= '0;
        idle_q[c]   <= '0;
      end
      en_q       <= '0;
      ack_q      <= '0;
      stop_req_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        state_q[c]    <= state_d[c];
        settle_q[c]   <= settle_d[c];
        idle_q[c]     <= idle_d[c];
        en_q[c]       <= (state_d[c] != StOff);
        ack_q[c]      <= (state_d[c] == StOn);
        stop_req_q[c] <= (state_d[c] == StDrain);
      end
    end
  end

  assign o_clk0_en   = en_q[0];
  assign o_clk1_en   = en_q[1];
  assign o_ack0      = ack_q[0];
  assign o_ack1      = ack_q[1];
  assign o_stop_req0 = stop_req_q[0];
  assign o_stop_req1 = stop_req_q[1];
  assign o_rst       = rst_q;
  assign o_ready     = ready_q;

endmodule

// File: tb/tb_servant_clock_ctrl.sv
// Directed bench for servant_clock_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_servant_clock_ctrl;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic i_locked = 1'b0;
  logic i_req0 = 1'b0, i_req1 = 1'b0;
  logic i_stop_ack0 = 1'b0, i_stop_ack1 = 1'b0;
  logic o_clk0_en, o_clk1_en, o_ack0, o_ack1, o_stop_req0, o_stop_req1, o_rst, o_ready;

  servant_clock_ctrl #(
    .RST_HOLD   (16),
    .IDLE_CYCLES(8),
    .WAKE_CYCLES(4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_locked   (i_locked),
    .i_req0     (i_req0),
    .i_req1     (i_req1),
    .i_stop_ack0(i_stop_ack0),
    .i_stop_ack1(i_stop_ack1),
    .o_clk0_en  (o_clk0_en),
    .o_clk1_en  (o_clk1_en),
    .o_ack0     (o_ack0),
    .o_ack1     (o_ack1),
    .o_stop_req0(o_stop_req0),
    .o_stop_req1(o_stop_req1),
    .o_rst      (o_rst),
    .o_ready    (o_ready)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] vec;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Channel codes are {en, ack, stop_req}.
  localparam logic [2:0] COff = 3'b000, CWake = 3'b100, COn = 3'b110, CDrn = 3'b101;

  function automatic logic [7:0] mk(logic rst, logic [2:0] c0, logic [2:0] c1);
    return {rst, ~rst, c0, c1};
  endfunction

  task automatic expect_at(int c, string name, logic [7:0] v);
    exp_t e;
    int idx;
    e.cyc  = c;
    e.name = name;
    e.vec  = v;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic negs(int k);
    repeat (k) @(negedge i_clk);
  endtask

  // Monitor: the outputs are observed every cycle; compare whatever is due now.
  initial begin
    exp_t e;
    logic [7:0] obs;
    forever begin
      @(negedge i_clk);
      obs = {o_rst, o_ready, o_clk0_en, o_ack0, o_stop_req0, o_clk1_en, o_ack1, o_stop_req1};
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          failures++;
          $display("FAIL %s: slot cycle %0d passed unchecked (now %0d)", e.name, e.cyc, cyc);
        end else if (obs !== e.vec) begin
          failures++;
          $display("FAIL %s @%0d: got %b required %b (rst rdy en0 ack0 sr0 en1 ack1 sr1)",
                   e.name, cyc, obs, e.vec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int b;
    // Reset held with lock and a request present: everything stays quiet.
    i_locked = 1'b1;
    i_req0   = 1'b1;
    negs(1);
    n = cyc;
    expect_at(n + 1, "reset_state", mk(1, COff, COff));
    expect_at(n + 3, "reset_state_hold", mk(1, COff, COff));
    negs(4);
    i_req0 = 1'b0;
    i_rst  = 1'b1;
    b = cyc + 1;
    expect_at(b + 1, "lock_hold_early", mk(1, COff, COff));
    expect_at(b + 17, "lock_hold_last", mk(1, COff, COff));
    expect_at(b + 18, "lock_ready", mk(0, COff, COff));
    negs(21);

    // Channel 0 wake-up; channel 1 untouched.
    n = cyc;
    i_req0 = 1'b1;
    expect_at(n + 1, "wake_en", mk(0, CWake, COff));
    expect_at(n + 4, "wake_last", mk(0, CWake, COff));
    expect_at(n + 5, "on_ack", mk(0, COn, COff));
    negs(6);
    n = cyc;
    i_stop_ack0 = 1'b1;
    expect_at(n + 1, "stop_ack_ignored_on", mk(0, COn, COff));
    negs(1);
    i_stop_ack0 = 1'b0;
    negs(3);

    // Idle timeout into drain, then stop handshake.
    n = cyc;
    i_req0 = 1'b0;
    expect_at(n + 7, "idle_still_on", mk(0, COn, COff));
    expect_at(n + 8, "idle_drain", mk(0, CDrn, COff));
    expect_at(n + 9, "drain_waits", mk(0, CDrn, COff));
    negs(9);
    n = cyc;
    i_stop_ack0 = 1'b1;
    expect_at(n + 1, "drain_to_off", mk(0, COff, COff));
    negs(1);
    i_stop_ack0 = 1'b0;

    // Drain with request and stop_ack together: request wins, idle count restarts.
    negs(2);
    n = cyc;
    i_req0 = 1'b1;
    expect_at(n + 5, "reon", mk(0, COn, COff));
    negs(6);
    n = cyc;
    i_req0 = 1'b0;
    expect_at(n + 8, "drain2", mk(0, CDrn, COff));
    negs(8);
    n = cyc;
    i_req0 = 1'b1;
    i_stop_ack0 = 1'b1;
    expect_at(n + 1, "req_wins", mk(0, COn, COff));
    negs(1);
    i_req0 = 1'b0;
    i_stop_ack0 = 1'b0;
    n = cyc;
    expect_at(n + 7, "idle_restart_on", mk(0, COn, COff));
    expect_at(n + 8, "idle_restart_drain", mk(0, CDrn, COff));
    negs(8);
    n = cyc;
    i_req0 = 1'b1;
    expect_at(n + 1, "drain_to_on", mk(0, COn, COff));

    // Bring up channel 1, then lose lock.
    negs(2);
    n = cyc;
    i_req1 = 1'b1;
    expect_at(n + 1, "ch1_wake", mk(0, COn, CWake));
    expect_at(n + 5, "both_on", mk(0, COn, COn));
    negs(7);
    n = cyc;
    i_locked = 1'b0;
    expect_at(n + 2, "lock_loss_pending", mk(0, COn, COn));
    expect_at(n + 3, "lock_loss", mk(1, COff, COff));
    negs(5);

    // Relock with requests still high: enables wait for o_ready.
    n = cyc;
    i_locked = 1'b1;
    b = n + 1;
    expect_at(b + 10, "relock_hold", mk(1, COff, COff));
    expect_at(b + 17, "relock_hold_last", mk(1, COff, COff));
    expect_at(b + 18, "relock_ready", mk(0, COff, COff));
    expect_at(b + 19, "relock_wake", mk(0, CWake, CWake));
    negs(20);

    // Asynchronous reset in the middle of WAKE.
    expect_at(cyc + 1, "async_reset", mk(1, COff, COff));
    @(posedge i_clk);
    #2;
    i_rst  = 1'b0;
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    negs(3);
    n = cyc;
    i_rst = 1'b1;
    b = n + 1;
    expect_at(b + 1, "post_reset_hold", mk(1, COff, COff));
    expect_at(b + 18, "post_reset_ready", mk(0, COff, COff));
    expect_at(b + 22, "no_en_glitch", mk(0, COff, COff));
    negs(23);
    n = cyc;
    i_req0 = 1'b1;
    expect_at(n + 1, "new_req_wake", mk(0, CWake, COff));

    for (int i = 0; i < 50 && sb.size() > 0; i++) negs(1);
    if (sb.size() > 0) begin
      $display("FAIL drain_queue: %0d expectations left unchecked, required 0", sb.size());
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
